// File: rtl/li_expander.sv
// li_expander: turns a 32-bit constant + rt into the shortest MIPS load sequence (1-2 words).
// Optional LI_EXPANDER_STATS_EN adds saturating request/word counters.
module li_expander (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rt,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last
`ifdef LI_EXPANDER_STATS_EN
    ,
    output logic [15:0] stat_req,
    output logic [15:0] stat_words
`endif
);

    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EMIT1 = 2'd1;
    localparam logic [1:0] EMIT2 = 2'd2;

    logic [1:0]  state;
    logic [4:0]  rt_q;
    logic [31:0] imm_q;

    logic sel_a, sel_b, sel_c, sel_d;
    logic req_fire, word_fire;
    logic [31:0] word1;
    logic        word1_last;

    assign req_fire  = in_valid & in_ready;
    assign word_fire = out_valid & out_ready;

    // Priority a > b > c > d, flattened into one-hot selects.
    assign sel_a = (&imm_q[31:15]) | ~(|imm_q[31:15]);
    assign sel_b = ~sel_a & ~(|imm_q[31:16]);
    assign sel_c = ~sel_a & ~sel_b & ~(|imm_q[15:0]);
    assign sel_d = ~sel_a & ~sel_b & ~sel_c;

    always_comb begin
        word1      = {OPC_LUI, 5'd0, rt_q, imm_q[31:16]};
        word1_last = 1'b0;
        unique case (1'b1)
            sel_a: begin
                word1      = {OPC_ADDIU, 5'd0, rt_q, imm_q[15:0]};
                word1_last = 1'b1;
            end
            sel_b: begin
                word1      = {OPC_ORI, 5'd0, rt_q, imm_q[15:0]};
                word1_last = 1'b1;
            end
            sel_c: begin
                word1      = {OPC_LUI, 5'd0, rt_q, imm_q[31:16]};
                word1_last = 1'b1;
            end
            sel_d: begin
                word1      = {OPC_LUI, 5'd0, rt_q, imm_q[31:16]};
                word1_last = 1'b0;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = 1'b0;
        out_inst  = 32'd0;
        out_last  = 1'b0;
        case (state)
            EMIT1: begin
                out_valid = 1'b1;
                out_inst  = word1;
                out_last  = word1_last;
            end
            EMIT2: begin
                out_valid = 1'b1;
                out_inst  = {OPC_ORI, rt_q, rt_q, imm_q[15:0]};
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rt_q  <= 5'd0;
            imm_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= EMIT1;
                        rt_q  <= in_rt;
                        imm_q <= in_imm;
                    end
                end
                EMIT1: begin
                    if (out_ready)
                        state <= word1_last ? IDLE : EMIT2;
                end
                EMIT2: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LI_EXPANDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_req   <= 16'd0;
            stat_words <= 16'd0;
        end else begin
            if (req_fire && stat_req != 16'hFFFF)
                stat_req <= stat_req + 16'd1;
            if (word_fire && stat_words != 16'hFFFF)
                stat_words <= stat_words + 16'd1;
        end
    end
`else
    logic unused_fire;
    assign unused_fire = req_fire ^ word_fire;
`endif

endmodule

// File: tb/tb_li_expander.sv
// tb_li_expander: directed checks of li_expander sequence selection, stalls and reset.
// Stats ports are exercised when LI_EXPANDER_STATS_EN is defined.
module tb_li_expander;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rt;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
`ifdef LI_EXPANDER_STATS_EN
    logic [15:0] stat_req;
    logic [15:0] stat_words;
`endif

    int pass_cnt;
    int total_cnt;

    li_expander dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rt     (in_rt),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_last  (out_last)
`ifdef LI_EXPANDER_STATS_EN
        ,
        .stat_req  (stat_req),
        .stat_words(stat_words)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [4:0] rt, input logic [31:0] imm);
        total_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL send_in_ready got=%b exp=1", in_ready);
        else
            pass_cnt++;
        in_valid = 1'b1;
        in_rt    = rt;
        in_imm   = imm;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1)
            $display("FAIL latency_out_valid imm=%h got=%b exp=1", imm, out_valid);
        else
            pass_cnt++;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_rt     = 5'd0;
        in_imm    = 32'd0;
        out_ready = 1'b0;
        #3;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_hs got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        else
            pass_cnt++;
        total_cnt++;
        if (out_inst !== 32'd0 || out_last !== 1'b0)
            $display("FAIL reset_out got inst=%h last=%b exp 0/0", out_inst, out_last);
        else
            pass_cnt++;
`ifdef LI_EXPANDER_STATS_EN
        total_cnt++;
        if (stat_req !== 16'd0 || stat_words !== 16'd0)
            $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_req, stat_words);
        else
            pass_cnt++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [4:0]  rt_v  [7];
        logic [31:0] imm_v [7];
        logic [31:0] exp_v [7];
        rt_v[0] = 5'd8;  imm_v[0] = 32'h00000005; exp_v[0] = 32'h24080005;
        rt_v[1] = 5'd9;  imm_v[1] = 32'hFFFF8000; exp_v[1] = 32'h24098000;
        rt_v[2] = 5'd10; imm_v[2] = 32'h0000ABCD; exp_v[2] = 32'h340AABCD;
        rt_v[3] = 5'd11; imm_v[3] = 32'h12340000; exp_v[3] = 32'h3C0B1234;
        rt_v[4] = 5'd3;  imm_v[4] = 32'h00000000; exp_v[4] = 32'h24030000;
        rt_v[5] = 5'd5;  imm_v[5] = 32'h00007FFF; exp_v[5] = 32'h24057FFF;
        rt_v[6] = 5'd0;  imm_v[6] = 32'h00010000; exp_v[6] = 32'h3C000001;
        for (int i = 0; i < 7; i++) begin
            send(rt_v[i], imm_v[i]);
            out_ready = 1'b1;
            total_cnt++;
            if (out_inst !== exp_v[i] || out_last !== 1'b1)
                $display("FAIL single_%0d got inst=%h last=%b exp inst=%h last=1",
                         i, out_inst, out_last, exp_v[i]);
            else
                pass_cnt++;
            @(negedge clk);
            out_ready = 1'b0;
            total_cnt++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL single_done_%0d got v=%b r=%b exp v=0 r=1",
                         i, out_valid, in_ready);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_two_word;
        send(5'd4, 32'h12345678);
        total_cnt++;
        if (out_inst !== 32'h3C041234 || out_last !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL two_w1 got inst=%h last=%b rdy=%b exp 3c041234/0/0",
                     out_inst, out_last, in_ready);
        else
            pass_cnt++;
        // A request arriving while busy must be ignored.
        in_valid = 1'b1;
        in_rt    = 5'd7;
        in_imm   = 32'h00000001;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total_cnt++;
        if (out_inst !== 32'h3C041234 || in_ready !== 1'b0)
            $display("FAIL busy_ignore got inst=%h rdy=%b exp 3c041234/0",
                     out_inst, in_ready);
        else
            pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_inst !== 32'h34845678 ||
            out_last !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL two_w2 got v=%b inst=%h last=%b rdy=%b exp 1/34845678/1/0",
                     out_valid, out_inst, out_last, in_ready);
        else
            pass_cnt++;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL two_done got v=%b r=%b exp 0/1", out_valid, in_ready);
        else
            pass_cnt++;
        send(5'd2, 32'hFFFF7FFF);
        out_ready = 1'b1;
        total_cnt++;
        if (out_inst !== 32'h3C02FFFF || out_last !== 1'b0)
            $display("FAIL neg_w1 got inst=%h last=%b exp 3c02ffff/0", out_inst, out_last);
        else
            pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_inst !== 32'h34427FFF || out_last !== 1'b1)
            $display("FAIL neg_w2 got inst=%h last=%b exp 34427fff/1", out_inst, out_last);
        else
            pass_cnt++;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_stall;
        send(5'd4, 32'h12345678);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_inst !== 32'h3C041234 || out_last !== 1'b0)
                $display("FAIL stall_w1_%0d got v=%b inst=%h last=%b exp 1/3c041234/0",
                         i, out_valid, out_inst, out_last);
            else
                pass_cnt++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_inst !== 32'h34845678 || out_last !== 1'b1)
                $display("FAIL stall_w2_%0d got v=%b inst=%h last=%b exp 1/34845678/1",
                         i, out_valid, out_inst, out_last);
            else
                pass_cnt++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL stall_done got v=%b r=%b exp 0/1", out_valid, in_ready);
        else
            pass_cnt++;
    endtask

    task automatic test_stats;
`ifdef LI_EXPANDER_STATS_EN
        // 7 singles + 2 pairs + 1 stalled pair since the last reset.
        total_cnt++;
        if (stat_req !== 16'd10 || stat_words !== 16'd13)
            $display("FAIL stats_count got %0d/%0d exp 10/13", stat_req, stat_words);
        else
            pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid;
        send(5'd4, 32'h12345678);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_inst !== 32'h34845678)
            $display("FAIL mid_pre got v=%b inst=%h exp 1/34845678", out_valid, out_inst);
        else
            pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'd0)
            $display("FAIL mid_async got v=%b r=%b inst=%h exp 0/1/0",
                     out_valid, in_ready, out_inst);
        else
            pass_cnt++;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL mid_after_%0d got v=%b r=%b exp 0/1", i, out_valid, in_ready);
            else
                pass_cnt++;
        end
        out_ready = 1'b0;
`ifdef LI_EXPANDER_STATS_EN
        total_cnt++;
        if (stat_req !== 16'd0 || stat_words !== 16'd0)
            $display("FAIL mid_stats got %0d/%0d exp 0/0", stat_req, stat_words);
        else
            pass_cnt++;
`endif
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_single();
        test_two_word();
        test_stall();
        test_stats();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
